// File: rtl/u409_cia_cycle_controller.sv
// u409_cia_cycle_controller
//   Generates the E clock for the two CIAs and sequences every CPU access
//   into the CIA address space. The E counter free-runs and is never stalled
//   by accesses. Each accepted request waits for the next usable E window,
//   asserts CIA_ENABLE from counter C = E_LOW-CS_SETUP up to and including
//   the counter-0 cycle after ECLK falls, and ends with a single-cycle TAn.
//
// Ports
//   CLK40       in   40 MHz clock, rising edge
//   RESETn      in   asynchronous active-low reset
//   TSn         in   CPU transfer start (active low, one cycle)
//   CIA_SPACE   in   decoded CIA address space
//   RnW         in   read(1) / write(0), valid with TSn
//   ECLK        out  E clock, high while counter >= E_LOW
//   CIA_ENABLE  out  chip-select qualifier returned to the address decode
//   CIA_DOE     out  drive write data onto the CIA data bus
//   CIA_DLE     out  read-data latch enable, one-cycle pulse
//   TAn         out  transfer acknowledge, active low
//   CIA_BUSY    out  request accepted and not yet terminated
module u409_cia_cycle_controller #(
  parameter int E_LOW    = 34,
  parameter int E_HIGH   = 22,
  parameter int CS_SETUP = 4
) (
  input  logic CLK40,
  input  logic RESETn,
  input  logic TSn,
  input  logic CIA_SPACE,
  input  logic RnW,
  output logic ECLK,
  output logic CIA_ENABLE,
  output logic CIA_DOE,
  output logic CIA_DLE,
  output logic TAn,
  output logic CIA_BUSY
);

  localparam int P  = E_LOW + E_HIGH;
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] CNT_LAST  = CW'(P - 1);
  localparam logic [CW-1:0] CNT_ELOW  = CW'(E_LOW);
  localparam logic [CW-1:0] CNT_C     = CW'(E_LOW - CS_SETUP);
  localparam logic [CW-1:0] CNT_PRE_C = CW'(E_LOW - CS_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    TERM   = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            rnw_reg, rnw_next;
  logic            eclk_reg, eclk_next;
  logic            enable_reg, enable_next;
  logic            doe_reg, doe_next;
  logic            dle_reg, dle_next;
  logic            tan_reg, tan_next;
  logic            busy_reg, busy_next;

  always_ff @(posedge CLK40 or negedge RESETn) begin
    if (!RESETn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rnw_reg    <= 1'b1;
      eclk_reg   <= 1'b0;
      enable_reg <= 1'b0;
      doe_reg    <= 1'b0;
      dle_reg    <= 1'b0;
      tan_reg    <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rnw_reg    <= rnw_next;
      eclk_reg   <= eclk_next;
      enable_reg <= enable_next;
      doe_reg    <= doe_next;
      dle_reg    <= dle_next;
      tan_reg    <= tan_next;
      busy_reg   <= busy_next;
    end
  end

  // All outputs are computed from the next counter/state so that each
  // registered output lines up with the counter value it belongs to.
  always_comb begin
    state_next = state_reg;
    rnw_next   = rnw_reg;
    cnt_next   = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (!TSn && CIA_SPACE) begin
          state_next = WAIT;
          rnw_next   = RnW;
        end
      end
      // Leaving on the edge where the counter becomes C means a request
      // accepted at C-1 (or later) can only catch the next period.
      WAIT:    if (cnt_reg == CNT_PRE_C) state_next = ACTIVE;
      ACTIVE:  if (cnt_reg == CNT_LAST)  state_next = TERM;
      TERM:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    eclk_next   = (cnt_next >= CNT_ELOW);
    // TERM keeps the enable/data drive asserted for CIA hold time.
    enable_next = (state_next == ACTIVE) || (state_next == TERM);
    doe_next    = enable_next && !rnw_next;
    dle_next    = (state_next == ACTIVE) && rnw_next && (cnt_next == CNT_LAST);
    tan_next    = (state_next != TERM);
    busy_next   = (state_next != IDLE);
  end

  assign ECLK       = eclk_reg;
  assign CIA_ENABLE = enable_reg;
  assign CIA_DOE    = doe_reg;
  assign CIA_DLE    = dle_reg;
  assign TAn        = tan_reg;
  assign CIA_BUSY   = busy_reg;

endmodule

// File: tb/tb_u409_cia_cycle_controller.sv
// Directed bench for u409_cia_cycle_controller. The bench keeps its own copy
// of the E counter (cnt_m), advanced once per rising edge; outputs are
// sampled on the falling edge, where they correspond to cnt_m.
`timescale 1ns/1ps
module tb_u409_cia_cycle_controller;

  logic CLK40 = 1'b0;
  logic RESETn = 1'b0;
  logic TSn = 1'b1;
  logic CIA_SPACE = 1'b0;
  logic RnW = 1'b1;
  logic ECLK, CIA_ENABLE, CIA_DOE, CIA_DLE, TAn, CIA_BUSY;

  int checks = 0;
  int errors = 0;
  int cnt_m  = 0;

  u409_cia_cycle_controller dut (
    .CLK40      (CLK40),
    .RESETn     (RESETn),
    .TSn        (TSn),
    .CIA_SPACE  (CIA_SPACE),
    .RnW        (RnW),
    .ECLK       (ECLK),
    .CIA_ENABLE (CIA_ENABLE),
    .CIA_DOE    (CIA_DOE),
    .CIA_DLE    (CIA_DLE),
    .TAn        (TAn),
    .CIA_BUSY   (CIA_BUSY)
  );

  always #5 CLK40 = ~CLK40;

  // {ECLK, CIA_ENABLE, CIA_DOE, CIA_DLE, TAn, CIA_BUSY}
  function automatic logic [5:0] outs();
    return {ECLK, CIA_ENABLE, CIA_DOE, CIA_DLE, TAn, CIA_BUSY};
  endfunction

  function automatic logic eclk_exp(input int c);
    return (c >= 34);
  endfunction

  task automatic tick();
    @(posedge CLK40);
    cnt_m = (cnt_m + 1) % 56;
    @(negedge CLK40);
  endtask

  task automatic wait_cnt(input int c);
    for (int i = 0; i < 56 && cnt_m != c; i++) tick();
  endtask

  // Release reset on a falling edge: the counter is 0 until the next rise.
  task automatic release_reset();
    @(negedge CLK40);
    RESETn = 1'b1;
    cnt_m  = 0;
  endtask

  task automatic idle_run(input int n, input string name);
    logic [5:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = {eclk_exp(cnt_m), 5'b00010};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL %s cnt=%0d outs=%b expected=%b", name, cnt_m, outs(), exp);
      end
      tick();
    end
  endtask

  // One access sampled at counter c; exp_lat is the hand-computed number of
  // cycles from the sampling edge to TAn low. ts2_k > 0 injects a second
  // (write) TSn that many cycles after acceptance, which must be ignored.
  task automatic run_access(input int c, input logic rnw, input int exp_lat,
                            input int ts2_k, input string name);
    logic [5:0] exp;
    logic en;
    int first_ta;
    first_ta = -1;
    wait_cnt(c);
    TSn = 1'b0; CIA_SPACE = 1'b1; RnW = rnw;
    tick();
    // Changes after acceptance must not affect the committed cycle.
    TSn = 1'b1; CIA_SPACE = 1'b0; RnW = ~rnw;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      en  = (k >= exp_lat - 26) && (k <= exp_lat);
      exp = {eclk_exp(cnt_m), en, en && !rnw, rnw && (k == exp_lat - 1),
             (k != exp_lat), (k <= exp_lat)};
      if (TAn === 1'b0 && first_ta < 0) first_ta = k;
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL %s k=%0d cnt=%0d outs=%b expected=%b", name, k, cnt_m, outs(), exp);
      end
      if (k == ts2_k) begin
        TSn = 1'b0; CIA_SPACE = 1'b1; RnW = 1'b0;
      end
      tick();
      TSn = 1'b1; CIA_SPACE = 1'b0;
    end
    checks++;
    if (first_ta !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency got=%0d expected=%0d", name, first_ta, exp_lat);
    end
    $display("%s: sampled at c=%0d, TAn after %0d cycles", name, c, first_ta);
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(negedge CLK40);
    checks++;
    if (outs() !== 6'b000010) begin
      errors++;
      $display("FAIL reset_state outs=%b expected=%b", outs(), 6'b000010);
    end
    release_reset();
    $display("test_reset done");
  endtask

  task automatic test_eclk();
    int lows, highs, rise_at;
    logic prev;
    lows = 0; highs = 0; rise_at = -1; prev = 1'b0;
    for (int i = 0; i < 56; i++) begin
      if (ECLK === 1'b1) highs++; else lows++;
      if (ECLK === 1'b1 && prev === 1'b0 && rise_at < 0) rise_at = cnt_m;
      prev = ECLK;
      tick();
    end
    checks++;
    if (lows !== 34) begin errors++; $display("FAIL eclk_low got=%0d expected=34", lows); end
    checks++;
    if (highs !== 22) begin errors++; $display("FAIL eclk_high got=%0d expected=22", highs); end
    checks++;
    if (rise_at !== 34) begin errors++; $display("FAIL eclk_rise got=%0d expected=34", rise_at); end
    idle_run(56, "eclk_idle");
    $display("test_eclk: low=%0d high=%0d rise_at=%0d", lows, highs, rise_at);
  endtask

  task automatic test_read();
    run_access(5, 1'b1, 51, 0, "read_c5");
    run_access(29, 1'b1, 83, 0, "read_c29");
    run_access(28, 1'b1, 28, 0, "read_c28");
    run_access(40, 1'b1, 72, 0, "read_c40");
  endtask

  task automatic test_write();
    run_access(10, 1'b0, 46, 0, "write_c10");
  endtask

  task automatic test_reset_mid_access();
    wait_cnt(5);
    TSn = 1'b0; CIA_SPACE = 1'b1; RnW = 1'b1;
    tick();
    TSn = 1'b1; CIA_SPACE = 1'b0;
    wait_cnt(40);
    checks++;
    if (CIA_ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre enable=%b expected=1", CIA_ENABLE);
    end
    RESETn = 1'b0;
    #1;
    checks++;
    if (outs() !== 6'b000010) begin
      errors++;
      $display("FAIL midreset_async outs=%b expected=%b", outs(), 6'b000010);
    end
    repeat (2) @(negedge CLK40);
    release_reset();
    idle_run(120, "midreset_after");
    $display("test_reset_mid_access done");
  endtask

  task automatic test_ignored();
    wait_cnt(3);
    TSn = 1'b0; CIA_SPACE = 1'b0; RnW = 1'b1;
    tick();
    TSn = 1'b1;
    idle_run(60, "nospace");
    run_access(5, 1'b1, 51, 10, "busy_ts");
    idle_run(120, "busy_ts_after");
  endtask

  task automatic test_back_to_back();
    // Request on the cycle right after TAn returns high.
    run_access(2, 1'b0, 54, 0, "b2b_first");
    run_access(2, 1'b1, 54, 0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_eclk();
    test_read();
    test_write();
    test_reset_mid_access();
    test_ignored();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
